// File: rtl/snn_pkg.sv
// Shared types and defaults for the spiking output-layer readout blocks.
// No timing of its own; width and state definitions only.
package snn_pkg;

  // Default accumulator count width, shared with the accumulator element.
  localparam int SNN_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/spike_argmax_step.sv
// One compare/update stage of the argmax scan; purely combinational, 0 cycles.
// Strict greater-than keeps the lowest index on ties; no handshake, no backpressure.
module spike_argmax_step #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  input  logic [DATA_WIDTH-1:0] i_run_max,
  input  logic [IDX_WIDTH-1:0]  i_run_idx,
  input  logic                  i_run_tie,
  output logic [DATA_WIDTH-1:0] o_nxt_max,
  output logic [IDX_WIDTH-1:0]  o_nxt_idx,
  output logic                  o_nxt_tie
);

  always_comb begin
    o_nxt_max = i_run_max;
    o_nxt_idx = i_run_idx;
    o_nxt_tie = i_run_tie;
    if (i_value > i_run_max) begin
      o_nxt_max = i_value;
      o_nxt_idx = i_idx;
      o_nxt_tie = 1'b0;
    end else if ((i_value == i_run_max) && (i_run_max != '0)) begin
      // Equal zero counts are not a tie; that case is reported as no_spike.
      o_nxt_tie = 1'b1;
    end
  end

endmodule

// File: rtl/spike_count_argmax.sv
// Snapshots all spike counts on start, scans one neuron per cycle; result valid NUM_NEURONS+1 cycles after start.
// Result is held in HOLD until out_ready; start outside IDLE is dropped, acc_clear pulses once per accepted start.
module spike_count_argmax
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH  = SNN_DATA_WIDTH,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] counts,
  input  logic                              start,
  output logic                              busy,
  output logic                              acc_clear,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [IDX_WIDTH-1:0]              class_idx,
  output logic [DATA_WIDTH-1:0]             max_count,
  output logic                              tie,
  output logic                              no_spike
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  state_e                r_state;
  logic [DATA_WIDTH-1:0] r_snap [NUM_NEURONS];
  logic [IDX_WIDTH-1:0]  r_ptr;
  logic [DATA_WIDTH-1:0] r_run_max;
  logic [IDX_WIDTH-1:0]  r_run_idx;
  logic                  r_run_tie;
  logic                  r_acc_clear;
  logic                  r_out_valid;
  logic [IDX_WIDTH-1:0]  r_class_idx;
  logic [DATA_WIDTH-1:0] r_max_count;
  logic                  r_tie;
  logic                  r_no_spike;

  logic [DATA_WIDTH-1:0] w_value;
  logic [DATA_WIDTH-1:0] w_nxt_max;
  logic [IDX_WIDTH-1:0]  w_nxt_idx;
  logic                  w_nxt_tie;

  assign w_value = r_snap[r_ptr];

  spike_argmax_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_step (
    .i_value   (w_value),
    .i_idx     (r_ptr),
    .i_run_max (r_run_max),
    .i_run_idx (r_run_idx),
    .i_run_tie (r_run_tie),
    .o_nxt_max (w_nxt_max),
    .o_nxt_idx (w_nxt_idx),
    .o_nxt_tie (w_nxt_tie)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_run_max   <= '0;
      r_run_idx   <= '0;
      r_run_tie   <= 1'b0;
      r_acc_clear <= 1'b0;
      r_out_valid <= 1'b0;
      r_class_idx <= '0;
      r_max_count <= '0;
      r_tie       <= 1'b0;
      r_no_spike  <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_snap[i] <= '0;
      end
    end else begin
      r_acc_clear <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              r_snap[i] <= counts[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_ptr       <= '0;
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_run_tie   <= 1'b0;
            r_acc_clear <= 1'b1;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_run_max <= w_nxt_max;
          r_run_idx <= w_nxt_idx;
          r_run_tie <= w_nxt_tie;
          if (r_ptr == LAST_IDX) begin
            // Publish straight from the last step so the result lands with out_valid.
            r_class_idx <= w_nxt_idx;
            r_max_count <= w_nxt_max;
            r_tie       <= w_nxt_tie;
            r_no_spike  <= (w_nxt_max == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_HOLD;
          end else begin
            r_ptr <= r_ptr + IDX_WIDTH'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign acc_clear = r_acc_clear;
  assign out_valid = r_out_valid;
  assign class_idx = r_class_idx;
  assign max_count = r_max_count;
  assign tie       = r_tie;
  assign no_spike  = r_no_spike;

endmodule
